drink_window_sched: RTL



---
 rtl/drink_disp_pkg.sv | 15 +
 rtl/drink_win_hit.sv | 37 +++
 rtl/drink_window_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/drink_disp_pkg.sv
// Shared definitions for the drink display path: window geometry and descriptor layout.
package drink_disp_pkg;
    localparam int WIN_W    = 200;
    localparam int WIN_H    = 200;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int ADDR_W   = 17;
    localparam int BORDER   = 2;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        en;
    } win_desc_t;
endpackage

// File: rtl/drink_win_hit.sv
// Combinational per-window test: interior hit, highlight ring, and ROM linear address.
module drink_win_hit
    import drink_disp_pkg::*;
(
    input  win_desc_t           desc,
    input  logic [10:0]         px_x,
    input  logic [10:0]         px_y,
    output logic                hit,
    output logic                ring,
    output logic [ADDR_W-1:0]   addr
);
    localparam logic signed [12:0] W_M1 = 13'(WIN_W - 1);
    localparam logic signed [12:0] H_M1 = 13'(WIN_H - 1);
    localparam logic signed [12:0] BRD  = 13'(BORDER);

    // Signed headroom keeps ox-BORDER at origin 0 negative instead of wrapping.
    logic signed [12:0] sx, sy, ox, oy;
    logic               in_x, in_y, box_x, box_y;
    logic [7:0]         dx, dy;

    assign sx = {2'b00, px_x};
    assign sy = {2'b00, px_y};
    assign ox = {2'b00, desc.x};
    assign oy = {2'b00, desc.y};

    assign in_x  = (sx >= ox) && (sx <= ox + W_M1);
    assign in_y  = (sy >= oy) && (sy <= oy + H_M1);
    assign box_x = (sx >= ox - BRD) && (sx <= ox + W_M1 + BRD);
    assign box_y = (sy >= oy - BRD) && (sy <= oy + H_M1 + BRD);

    assign hit  = desc.en & in_x & in_y;
    assign ring = box_x & box_y & ~(in_x & in_y);

    assign dx   = 8'(px_x - desc.x);
    assign dy   = 8'(px_y - desc.y);
    assign addr = ADDR_W'(dy) * ADDR_W'(WIN_W) + ADDR_W'(dx);
endmodule

// File: rtl/drink_window_sched.sv
// Per-pixel window arbitration for the shared drink ROM, with frame-committed config and blinking highlight.
module drink_window_sched
    import drink_disp_pkg::*;
#(
    parameter int NUM_WIN      = 4,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                clk_40M,
    input  logic                Reset_n,
    input  logic [10:0]         px_x,
    input  logic [10:0]         px_y,
    input  logic                px_active,
    input  logic                frame_start,
    input  logic                cfg_wr,
    input  logic [1:0]          cfg_idx,
    input  logic [10:0]         cfg_x,
    input  logic [10:0]         cfg_y,
    input  logic                cfg_en,
    input  logic                sel_valid,
    input  logic [1:0]          sel_idx,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic [1:0]          rom_sel,
    output logic                win_hit,
    output logic                border_on,
    output logic                pix_active_o
);
    localparam int CW = $clog2(BLINK_FRAMES);

    win_desc_t [NUM_WIN-1:0]             pend_q, pend_nxt, act_q;
    logic [NUM_WIN-1:0]                  hit_v, ring_v;
    logic [NUM_WIN-1:0][ADDR_W-1:0]      addr_v;
    logic                                hl_vld;
    logic [1:0]                          hl_idx;
    logic [CW-1:0]                       blink_cnt;
    logic                                blink_ph;
    logic                                any_hit, brd;
    logic [1:0]                          hit_idx;
    logic [ADDR_W-1:0]                   hit_addr;
    logic [ROM_LAT:0]                    hit_p, brd_p, vld_pipe;

    // Commit sees pending-next so a write landing on frame_start is included.
    always_comb begin
        pend_nxt = pend_q;
        if (cfg_wr) pend_nxt[cfg_idx] = '{x: cfg_x, y: cfg_y, en: cfg_en};
    end

    always_ff @(posedge clk_40M) begin
        if (!Reset_n) begin
            pend_q    <= '0;
            act_q     <= '0;
            hl_vld    <= 1'b0;
            hl_idx    <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            if (frame_start) begin
                act_q  <= pend_nxt;
                hl_vld <= sel_valid;
                hl_idx <= sel_idx;
                if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        drink_win_hit u_hit (
            .desc (act_q[i]),
            .px_x (px_x),
            .px_y (px_y),
            .hit  (hit_v[i]),
            .ring (ring_v[i]),
            .addr (addr_v[i])
        );
    end

    // Scan high to low so the lowest index is the last to claim the pixel.
    always_comb begin
        any_hit  = 1'b0;
        hit_idx  = '0;
        hit_addr = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                any_hit  = 1'b1;
                hit_idx  = 2'(i);
                hit_addr = addr_v[i];
            end
        end
    end

    assign brd = px_active & hl_vld & blink_ph & act_q[hl_idx].en & ring_v[hl_idx];

    always_ff @(posedge clk_40M) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            rom_sel  <= '0;
            hit_p    <= '0;
            brd_p    <= '0;
            vld_pipe <= '0;
        end else begin
            rom_addr <= (any_hit & px_active) ? hit_addr : '0;
            if (any_hit & px_active) rom_sel <= hit_idx;
            hit_p    <= {hit_p[ROM_LAT-1:0], any_hit & px_active};
            brd_p    <= {brd_p[ROM_LAT-1:0], brd};
            vld_pipe <= {vld_pipe[ROM_LAT-1:0], px_active};
        end
    end

    assign win_hit      = hit_p[ROM_LAT];
    assign border_on    = brd_p[ROM_LAT];
    assign pix_active_o = vld_pipe[ROM_LAT];
endmodule
